// File: rtl/plataform_renderer.sv
// Purpose: render RGB332 pixels for a scrolling platform with a hole; bounds shadowed once per frame.
// Latency: 2 clk from pixel/sync inputs to rgb, in_plataform, hsync_out, vsync_out, video_on_out.
// Backpressure: none; a free-running pixel stream is accepted every clock.
// Optional build macro PLAT_BORDER_EN: top and bottom platform rows render EDGE_COLOR.
module plataform_renderer #(
    parameter logic [9:0] H_ACTIVE   = 10'd640,
    parameter logic [9:0] V_ACTIVE   = 10'd480,
    parameter logic [7:0] PLAT_COLOR = 8'hB6,
    parameter logic [7:0] BG_COLOR   = 8'h03,
    parameter logic [7:0] EDGE_COLOR = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       frame_start,
    input  logic [9:0] plataform_start,
    input  logic [9:0] plataform_end,
    input  logic [9:0] hole_start,
    input  logic [9:0] hole_end,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       video_on_out,
    output logic       in_plataform
);

    // Shadow bounds: only these feed the render path, so bound inputs may change freely mid-frame.
    logic [9:0] s_plat_start_q, s_plat_end_q, s_hole_start_q, s_hole_end_q;

    // Stage-1 registers.
    logic row_hit_q, col_hole_q, col_ok_q;
    logic vid1_q, hs1_q, vs1_q;
    logic row_hit_d, col_hole_d, col_ok_d;

    // Stage-2 registers (drive the outputs directly).
    logic [7:0] rgb_q, rgb_d;
    logic       in_plat_q, in_plat_d;
    logic       vid2_q, hs2_q, vs2_q;

`ifdef PLAT_BORDER_EN
    logic edge_q, edge_d;
`endif

    // Shadow latch: new bounds take effect the cycle after the frame_start pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_plat_start_q <= '0;
            s_plat_end_q   <= '0;
            s_hole_start_q <= '0;
            s_hole_end_q   <= '0;
        end else if (frame_start) begin
            s_plat_start_q <= plataform_start;
            s_plat_end_q   <= plataform_end;
            s_hole_start_q <= hole_start;
            s_hole_end_q   <= hole_end;
        end
    end

    // Stage-1 compares; an empty or inverted range simply never matches, so no wrap handling is needed.
    always_comb begin
        row_hit_d  = (pixel_y >= s_plat_start_q) && (pixel_y < s_plat_end_q) && (pixel_y < V_ACTIVE);
        col_hole_d = (s_hole_end_q > s_hole_start_q) && (pixel_x >= s_hole_start_q)
                     && (pixel_x < s_hole_end_q);
        col_ok_d   = (pixel_x < H_ACTIVE);
`ifdef PLAT_BORDER_EN
        // row_hit_d guarantees a non-empty platform, so s_plat_end_q - 1 cannot underflow here.
        edge_d     = row_hit_d && ((pixel_y == s_plat_start_q) || (pixel_y == s_plat_end_q - 10'd1));
`endif
    end

    // Stage-1 pipeline: compare results plus sync/blank aligned with them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_hit_q  <= 1'b0;
            col_hole_q <= 1'b0;
            col_ok_q   <= 1'b0;
            vid1_q     <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
`ifdef PLAT_BORDER_EN
            edge_q     <= 1'b0;
`endif
        end else begin
            row_hit_q  <= row_hit_d;
            col_hole_q <= col_hole_d;
            col_ok_q   <= col_ok_d;
            vid1_q     <= video_on;
            hs1_q      <= hsync_in;
            vs1_q      <= vsync_in;
`ifdef PLAT_BORDER_EN
            edge_q     <= edge_d;
`endif
        end
    end

    // Stage-2 colour select: blanking forces black, otherwise platform vs background.
    always_comb begin
        rgb_d     = 8'h00;
        in_plat_d = 1'b0;
        if (vid1_q) begin
            if (row_hit_q && col_ok_q && !col_hole_q) begin
                in_plat_d = 1'b1;
`ifdef PLAT_BORDER_EN
                rgb_d     = edge_q ? EDGE_COLOR : PLAT_COLOR;
`else
                rgb_d     = PLAT_COLOR;
`endif
            end else begin
                rgb_d     = BG_COLOR;
            end
        end
    end

    // Stage-2 pipeline: output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_q     <= 8'h00;
            in_plat_q <= 1'b0;
            vid2_q    <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            in_plat_q <= in_plat_d;
            vid2_q    <= vid1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

    assign rgb          = rgb_q;
    assign in_plataform = in_plat_q;
    assign video_on_out = vid2_q;
    assign hsync_out    = hs2_q;
    assign vsync_out    = vs2_q;

endmodule

// File: tb/tb_plataform_renderer.sv
// Purpose: directed self-checking bench for plataform_renderer with hand-computed colours.
// Latency: checks outputs 2 clk after each presented pixel.
// Backpressure: none; stimulus is driven on falling edges, outputs sampled away from rising edges.
module tb_plataform_renderer;

    localparam logic [7:0] PLAT = 8'hB6;
    localparam logic [7:0] BG   = 8'h03;
`ifdef PLAT_BORDER_EN
    localparam logic [7:0] ROW_EDGE = 8'hFF;
`else
    localparam logic [7:0] ROW_EDGE = 8'hB6;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, hsync_in, vsync_in, frame_start;
    logic [9:0] plataform_start, plataform_end, hole_start, hole_end;
    logic [7:0] rgb;
    logic       hsync_out, vsync_out, video_on_out, in_plataform;

    int n_checks = 0;
    int n_pass   = 0;

    plataform_renderer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .video_on        (video_on),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .frame_start     (frame_start),
        .plataform_start (plataform_start),
        .plataform_end   (plataform_end),
        .hole_start      (hole_start),
        .hole_end        (hole_end),
        .rgb             (rgb),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .video_on_out    (video_on_out),
        .in_plataform    (in_plataform)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Load bounds onto the inputs and pulse frame_start for one cycle.
    task automatic latch_bounds(input logic [9:0] ps, input logic [9:0] pe,
                                input logic [9:0] hs, input logic [9:0] he);
        @(negedge clk);
        plataform_start = ps;
        plataform_end   = pe;
        hole_start      = hs;
        hole_end        = he;
        frame_start     = 1'b1;
        @(negedge clk);
        frame_start     = 1'b0;
    endtask

    // Present one pixel, wait the 2-cycle latency, compare colour and platform flag.
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic vo,
                       input logic [7:0] exp_rgb, input logic exp_in);
        @(negedge clk);
        pixel_x  = x;
        pixel_y  = y;
        video_on = vo;
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
        check_val({tag, ".in"}, 32'(in_plataform), 32'(exp_in));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hpat, vpat, opat;
        reset_n = 1'b0;
        pixel_x = 10'd50; pixel_y = 10'd110; video_on = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
        plataform_start = '0; plataform_end = '0; hole_start = '0; hole_end = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.rgb", 32'(rgb), 32'h0);
        check_val("rst.hs", 32'(hsync_out), 32'h0);
        check_val("rst.vs", 32'(vsync_out), 32'h0);
        check_val("rst.vo", 32'(video_on_out), 32'h0);
        check_val("rst.in", 32'(in_plataform), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Empty shadows after reset: nothing drawn.
        pix("empty_after_rst", 10'd50, 10'd110, 1'b1, BG, 1'b0);

        latch_bounds(10'd100, 10'd130, 10'd200, 10'd260);
        pix("solid",       10'd50,  10'd110, 1'b1, PLAT, 1'b1);
        pix("in_hole",     10'd220, 10'd110, 1'b1, BG,   1'b0);
        pix("hole_start",  10'd200, 10'd110, 1'b1, BG,   1'b0);
        pix("before_hole", 10'd199, 10'd110, 1'b1, PLAT, 1'b1);
        pix("hole_end_ex", 10'd260, 10'd110, 1'b1, PLAT, 1'b1);
        pix("above",       10'd10,  10'd99,  1'b1, BG,   1'b0);
        pix("top_row",     10'd10,  10'd100, 1'b1, ROW_EDGE, 1'b1);
        pix("mid_row",     10'd10,  10'd115, 1'b1, PLAT, 1'b1);
        pix("bot_row",     10'd10,  10'd129, 1'b1, ROW_EDGE, 1'b1);
        pix("end_ex",      10'd10,  10'd130, 1'b1, BG,   1'b0);
        pix("x_offscreen", 10'd650, 10'd110, 1'b1, BG,   1'b0);

        // Platform extending past the last visible line.
        latch_bounds(10'd470, 10'd500, 10'd0, 10'd0);
        pix("clip_last",   10'd10, 10'd479, 1'b1, PLAT, 1'b1);
        pix("blank",       10'd10, 10'd490, 1'b0, 8'h00, 1'b0);
        pix("y_offscreen", 10'd10, 10'd490, 1'b1, BG,   1'b0);

        // Inputs changing without frame_start must not affect rendering.
        latch_bounds(10'd100, 10'd130, 10'd200, 10'd260);
        @(negedge clk);
        plataform_start = 10'd300; plataform_end = 10'd330;
        pix("no_latch", 10'd5, 10'd110, 1'b1, PLAT, 1'b1);
        // Pixel presented in the same cycle as frame_start still sees old shadows.
        @(negedge clk);
        pixel_x = 10'd5; pixel_y = 10'd110; video_on = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pixel_y = 10'd310;
        @(posedge clk);
        #1;
        check_val("same_cycle_old.rgb", 32'(rgb), 32'(PLAT));
        pix("after_latch_old", 10'd5, 10'd110, 1'b1, BG,   1'b0);
        pix("after_latch_new", 10'd5, 10'd310, 1'b1, PLAT, 1'b1);

        // Inverted platform range renders nothing.
        latch_bounds(10'd130, 10'd100, 10'd0, 10'd0);
        pix("inverted", 10'd5, 10'd115, 1'b1, BG, 1'b0);

        // Hole past the right edge and an inverted hole.
        latch_bounds(10'd100, 10'd130, 10'd600, 10'd900);
        pix("hole_clip_in",  10'd630, 10'd110, 1'b1, BG,   1'b0);
        pix("hole_clip_out", 10'd599, 10'd110, 1'b1, PLAT, 1'b1);
        latch_bounds(10'd100, 10'd130, 10'd300, 10'd200);
        pix("no_hole", 10'd250, 10'd115, 1'b1, PLAT, 1'b1);

        // Sync/blank pattern reproduced exactly 2 cycles later.
        hpat = 8'b1011_0010;
        vpat = 8'b0110_1001;
        opat = 8'b1100_1010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check_val($sformatf("hs_pipe%0d", i), 32'(hsync_out), 32'(hpat[i-2]));
                check_val($sformatf("vs_pipe%0d", i), 32'(vsync_out), 32'(vpat[i-2]));
                check_val($sformatf("vo_pipe%0d", i), 32'(video_on_out), 32'(opat[i-2]));
            end
            if (i < 8) begin
                hsync_in = hpat[i];
                vsync_in = vpat[i];
                video_on = opat[i];
            end
        end

        // Reset mid-line: outputs clear on the next edge, shadows become empty.
        hsync_in = 1'b1; vsync_in = 1'b1;
        pix("pre_rst", 10'd50, 10'd110, 1'b1, PLAT, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst.rgb", 32'(rgb), 32'h0);
        check_val("midrst.in", 32'(in_plataform), 32'h0);
        check_val("midrst.hs", 32'(hsync_out), 32'h0);
        check_val("midrst.vs", 32'(vsync_out), 32'h0);
        check_val("midrst.vo", 32'(video_on_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        pix("post_rst_empty", 10'd50, 10'd110, 1'b1, BG, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
